// File: rtl/rle_sched_pkg.sv
// rtl/rle_sched_pkg.sv - shared FSM states, block constants and block-type decode for the RLE block scheduler
//
// Purpose : types and constants shared by rle_block_sched and blk_counter.
// Contents: sched_state_t (IDLE/LAUNCH/RUN), BLOCKS_PER_MB, LAST_BLK_IDX,
//           block-type codes BLK_Y/BLK_CB/BLK_CR and the blk_type_of() decode.
package rle_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } sched_state_t;

  localparam int BLOCKS_PER_MB = 6;
  localparam logic [2:0] LAST_BLK_IDX = 3'(BLOCKS_PER_MB - 1);

  localparam logic [1:0] BLK_Y  = 2'd0;
  localparam logic [1:0] BLK_CB = 2'd1;
  localparam logic [1:0] BLK_CR = 2'd2;

  // 4:2:0 macroblock order: four luma blocks, then Cb, then Cr.
  function automatic logic [1:0] blk_type_of(input logic [2:0] idx);
    case (idx)
      3'd4:    return BLK_CB;
      3'd5:    return BLK_CR;
      default: return BLK_Y;
    endcase
  endfunction

endpackage

// File: rtl/rle_block_sched_blk_counter.sv
// rtl/rle_block_sched_blk_counter.sv - block position and macroblock counter for the RLE scheduler
//
// Purpose : tracks the block position inside a macroblock and counts completed macroblocks.
// Ports   : clk, reset      - clock, async active-high reset
//           advance         - one block finished encoding (step blk_idx)
//           blk_idx/blk_type- current block position 0..5 and its Y/Cb/Cr code
//           mb_done         - one-cycle pulse in the cycle after block 5 finishes
//           mb_count        - completed macroblocks, wraps at 2^MB_CNT_W
module blk_counter
  import rle_sched_pkg::*;
#(
  parameter int MB_CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                advance,
  output logic [2:0]          blk_idx,
  output logic [1:0]          blk_type,
  output logic                mb_done,
  output logic [MB_CNT_W-1:0] mb_count
);

  logic wrap;

  assign wrap = advance && (blk_idx == LAST_BLK_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_idx  <= '0;
      mb_done  <= 1'b0;
      mb_count <= '0;
    end else begin
      // Registered so the pulse lands in the cycle after the wrap edge.
      mb_done <= wrap;
      if (advance) begin
        blk_idx <= wrap ? 3'd0 : blk_idx + 3'd1;
      end
      if (wrap) begin
        mb_count <= mb_count + 1'b1;
      end
    end
  end

  assign blk_type = blk_type_of(blk_idx);

endmodule

// File: rtl/rle_block_sched.sv
// rtl/rle_block_sched.sv - ping-pong coefficient buffer scheduler between DCT producer and RLE encoder
//
// Purpose : owns the two buffer-full flags and the write/read buffer selects, launches
//           the encoder on each filled buffer and counts blocks/macroblocks.
// Ports   : clk, reset             - clock, async active-high reset
//           prod_valid/prod_ready  - producer finished a block into wr_sel / wr_sel is free
//           wr_sel, rd_sel         - producer write buffer, encoder read buffer
//           enc_rdy, enc_en        - encoder idle / one-cycle encoder start
//           enc_end                - encoder accepted the last symbol of the block
//           blk_idx, blk_type      - block position 0..5 and Y/Cb/Cr code
//           mb_done, mb_count      - macroblock completion pulse and count
//           busy                   - any buffer full or encoder activity in flight
module rle_block_sched
  import rle_sched_pkg::*;
#(
  parameter int MB_CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                prod_valid,
  output logic                prod_ready,
  output logic                wr_sel,
  output logic                rd_sel,
  input  logic                enc_rdy,
  output logic                enc_en,
  input  logic                enc_end,
  output logic [2:0]          blk_idx,
  output logic [1:0]          blk_type,
  output logic                mb_done,
  output logic [MB_CNT_W-1:0] mb_count,
  output logic                busy
);

  sched_state_t state, state_nxt;
  logic [1:0]   full, full_nxt;
  logic         accept;
  logic         rel_blk;

  assign prod_ready = ~full[wr_sel];
  assign accept     = prod_valid & prod_ready;
  // enc_end only means something once the encoder has actually been started.
  assign rel_blk    = (state == ST_RUN) & enc_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    enc_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (full[rd_sel] && enc_rdy) begin
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        enc_en    = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (enc_end) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A fill and a release never target the same buffer: a fill needs
  // full[wr_sel]=0 while a release needs full[rd_sel]=1, so both apply.
  always_comb begin
    full_nxt = full;
    if (rel_blk) begin
      full_nxt[rd_sel] = 1'b0;
    end
    if (accept) begin
      full_nxt[wr_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        wr_sel <= ~wr_sel;
      end
      if (rel_blk) begin
        rd_sel <= ~rd_sel;
      end
    end
  end

  assign busy = (|full) | (state != ST_IDLE);

  blk_counter #(
    .MB_CNT_W(MB_CNT_W)
  ) u_blk_counter (
    .clk      (clk),
    .reset    (reset),
    .advance  (rel_blk),
    .blk_idx  (blk_idx),
    .blk_type (blk_type),
    .mb_done  (mb_done),
    .mb_count (mb_count)
  );

endmodule

// File: tb/tb_rle_block_sched.sv
// tb/tb_rle_block_sched.sv - scoreboard testbench for rle_block_sched
`timescale 1ns/1ps
module tb_rle_block_sched;

  localparam int W = 3;
  localparam int MB_MOD = 1 << W;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         prod_valid = 1'b0;
  logic         prod_ready;
  logic         wr_sel;
  logic         rd_sel;
  logic         enc_rdy = 1'b0;
  logic         enc_en;
  logic         enc_end = 1'b0;
  logic [2:0]   blk_idx;
  logic [1:0]   blk_type;
  logic         mb_done;
  logic [W-1:0] mb_count;
  logic         busy;

  always #5 clk = ~clk;

  rle_block_sched #(.MB_CNT_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .wr_sel     (wr_sel),
    .rd_sel     (rd_sel),
    .enc_rdy    (enc_rdy),
    .enc_en     (enc_en),
    .enc_end    (enc_end),
    .blk_idx    (blk_idx),
    .blk_type   (blk_type),
    .mb_done    (mb_done),
    .mb_count   (mb_count),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: blocks are served strictly in arrival order from a
  // two-deep store; block k since reset is macroblock position k mod 6.
  typedef struct {
    int rd;
    int idx;
    int typ;
  } launch_t;

  launch_t lq[$];
  int      mbq[$];
  int      exp_type[6] = '{0, 0, 0, 0, 1, 2};
  int      occ = 0, acc_cnt = 0, rel_cnt = 0, cd = 0;
  bit      in_run = 0, launch_prev = 0, rel_last = 0;
  int      pv_pct = 0, rdy_pct = 100, spur_pct = 0, run_max = 3;
  bit      chk_en = 0;

  // One clock of stimulus: account for what the DUT sampled at this edge,
  // then drive the inputs for the next edge.
  task automatic tick();
    bit      acc, rel;
    launch_t r;
    @(posedge clk);
    #1;
    acc = prod_valid && (occ < 2);
    rel = enc_end && in_run;
    rel_last = rel;
    if (acc) begin
      r.rd  = acc_cnt % 2;
      r.idx = acc_cnt % 6;
      r.typ = exp_type[acc_cnt % 6];
      lq.push_back(r);
      if (acc_cnt % 6 == 5) mbq.push_back(((acc_cnt / 6) + 1) % MB_MOD);
      acc_cnt++;
      occ++;
    end
    if (rel) begin
      rel_cnt++;
      occ--;
      in_run = 0;
    end
    if (launch_prev) begin
      in_run = 1;
      cd = int'($urandom_range(run_max, 0));
    end
    launch_prev = enc_en;
    prod_valid = ($urandom_range(99, 0) < pv_pct);
    enc_rdy    = !in_run && !launch_prev && ($urandom_range(99, 0) < rdy_pct);
    if (in_run) begin
      enc_end = (cd == 0);
      if (cd > 0) cd--;
    end else begin
      enc_end = ($urandom_range(99, 0) < spur_pct);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("rst_prod_ready", 32'(prod_ready), 32'd1);
    check("rst_enc_en", 32'(enc_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_blk_idx", 32'(blk_idx), 32'd0);
    check("rst_mb_count", 32'(mb_count), 32'd0);
    check("rst_mb_done", 32'(mb_done), 32'd0);
    check("rst_wr_sel", 32'(wr_sel), 32'd0);
    check("rst_rd_sel", 32'(rd_sel), 32'd0);
    prod_valid = 1'b0;
    enc_end = 1'b0;
    enc_rdy = 1'b0;
    occ = 0; acc_cnt = 0; rel_cnt = 0; cd = 0;
    in_run = 0; launch_prev = 0; rel_last = 0;
    lq.delete();
    mbq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    pv_pct = 0;
    spur_pct = 0;
    n = 0;
    while ((occ != 0 || in_run || launch_prev) && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s: drain timeout, occupancy %0d expected 0", name, occ);
    end
  endtask

  task automatic random_phase(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (i % 64 == 0) begin
        pv_pct   = int'($urandom_range(100, 20));
        rdy_pct  = int'($urandom_range(100, 30));
        spur_pct = int'($urandom_range(20, 0));
        run_max  = int'($urandom_range(6, 0));
      end
      tick();
    end
  endtask

  // Monitor / scoreboard, sampling on the falling edge.
  launch_t mr;
  bit      prev_en = 0;
  int      mb_exp;

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("prod_ready", 32'(prod_ready), 32'(occ < 2));
      check("busy", 32'(busy), 32'(occ > 0));
      check("wr_sel", 32'(wr_sel), 32'(acc_cnt % 2));
      check("rd_sel", 32'(rd_sel), 32'(rel_cnt % 2));
      check("blk_idx", 32'(blk_idx), 32'(rel_cnt % 6));
      check("blk_type", 32'(blk_type), 32'(exp_type[rel_cnt % 6]));
      check("mb_count", 32'(mb_count), 32'((rel_cnt / 6) % MB_MOD));
      check("mb_done", 32'(mb_done), 32'(rel_last && (rel_cnt % 6 == 0)));
      if (enc_en) begin
        check("enc_en_width", 32'(prev_en), 32'd0);
        if (lq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL launch_sb: enc_en with no block expected");
        end else begin
          mr = lq.pop_front();
          check("launch_rd_sel", 32'(rd_sel), 32'(mr.rd));
          check("launch_blk_idx", 32'(blk_idx), 32'(mr.idx));
          check("launch_blk_type", 32'(blk_type), 32'(mr.typ));
        end
      end
      if (mb_done) begin
        if (mbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mb_sb: mb_done with no macroblock expected");
        end else begin
          mb_exp = mbq.pop_front();
          check("mb_done_count", 32'(mb_count), 32'(mb_exp));
        end
      end
      prev_en = enc_en;
    end
  end

  initial begin
    int n;
    chk_en = 1;
    apply_reset();

    // Single block: earliest launch timing and buffer release.
    pv_pct = 100; rdy_pct = 100; spur_pct = 0; run_max = 3;
    tick();
    pv_pct = 0;
    tick();
    check("launch_lat_c1", 32'(enc_en), 32'd0);
    tick();
    check("launch_lat_c2", 32'(enc_en), 32'd1);
    check("single_rd_sel", 32'(rd_sel), 32'd0);
    check("single_blk_type", 32'(blk_type), 32'd0);
    wait_idle(200, "single_drain");
    check("single_rd_sel_after", 32'(rd_sel), 32'd1);
    check("single_busy_after", 32'(busy), 32'd0);

    // Back-to-back fills with a slow encoder: both buffers end up full.
    pv_pct = 100; rdy_pct = 100; run_max = 15;
    repeat (3) tick();
    check("b2b_prod_ready", 32'(prod_ready), 32'd0);
    wait_idle(500, "b2b_drain");

    random_phase(2500);
    wait_idle(1000, "rand1_drain");

    // Reset in the middle of block 3 with both buffers full.
    pv_pct = 100; rdy_pct = 100; spur_pct = 0; run_max = 4;
    n = 0;
    while (!(in_run && occ == 2 && rel_cnt % 6 == 3) && n < 2000) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= 2000) begin
      n_fail++;
      $display("FAIL midrun_setup: state not reached, occupancy %0d expected 2", occ);
    end
    check("midrun_blk_idx", 32'(blk_idx), 32'd3);
    apply_reset();

    // Long random run: many macroblocks, mb_count wraps several times.
    random_phase(3000);
    wait_idle(1000, "rand2_drain");
    repeat (3) tick();
    check("launch_queue_empty", 32'(lq.size()), 32'd0);
    check("mb_queue_empty", 32'(mbq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
